fetch_request_unit: RTL

- Instruction fetch front end; sits directly upstream of the instruction loop buffer.
- Owns the fetch PC and issues in-order word requests to the instruction memory/MMU port.
- Tracks outstanding requests and pairs each returned instruction with its PC and prediction tag.
- Discards stale responses after a refresh, and delivers one registered instruction per cycle to the loop buffer's PREVIOUS-side inputs.

---
 rtl/fetch_request_unit.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/fetch_request_unit.sv
// Fetch request unit: owns the fetch PC, issues in-order word requests,
// tracks in-flight requests in a tag FIFO and forwards each returned
// instruction (with PC and prediction tag) to the loop buffer one cycle later.
module fetch_request_unit #(
   parameter logic [31:0] P_RESET_PC        = 32'h0000_0000,
   parameter int unsigned P_MAX_OUTSTANDING = 4
) (
   input  logic        iCLOCK,
   input  logic        inRESET,
   input  logic        iFREE_REFRESH,
   input  logic [31:0] iREFRESH_PC,
   input  logic        iSYSREG_PAGING_ENA,
   input  logic        iSYSREG_KERNEL,
   input  logic        iBP_HIT,
   input  logic [31:0] iBP_ADDR,
   output logic        oMEM_REQ,
   output logic [31:0] oMEM_ADDR,
   input  logic        iMEM_BUSY,
   input  logic        iMEM_VALID,
   input  logic [31:0] iMEM_DATA,
   input  logic        iMEM_PAGEFAULT,
   input  logic [13:0] iMEM_MMU_FLAGS,
   output logic        oNEXT_INST_VALID,
   output logic        oNEXT_PAGEFAULT,
   output logic [13:0] oNEXT_MMU_FLAGS,
   output logic        oNEXT_PAGING_ENA,
   output logic        oNEXT_KERNEL_ACCESS,
   output logic        oNEXT_BRANCH_PREDICT,
   output logic [31:0] oNEXT_BRANCH_PREDICT_ADDR,
   output logic [31:0] oNEXT_INST,
   output logic [31:0] oNEXT_PC,
   input  logic        iNEXT_FETCH_STOP,
   input  logic        iNEXT_LOCK
);

   localparam int unsigned CNT_W = $clog2(P_MAX_OUTSTANDING + 1);
   localparam int unsigned PTR_W = $clog2(P_MAX_OUTSTANDING);

   typedef enum logic [0:0] {ST_INIT, ST_RUN} state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic        bp_hit;
      logic [31:0] bp_addr;
      logic        paging;
      logic        kernel;
   } tag_t;

   state_e             state_q, state_d;
   logic [31:0]        pc_q, pc_d;
   logic [CNT_W-1:0]   outst_q, outst_d;
   logic [CNT_W-1:0]   drop_q, drop_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   tag_t               tag_mem_q [P_MAX_OUTSTANDING];
   tag_t               tag_in_c, tag_out_c;

   logic               valid_q, valid_d;
   logic               pf_q, pf_d;
   logic [13:0]        flags_q, flags_d;
   logic               paging_q, paging_d;
   logic               kernel_q, kernel_d;
   logic               bp_q, bp_d;
   logic [31:0]        bp_addr_q, bp_addr_d;
   logic [31:0]        inst_q, inst_d;
   logic [31:0]        npc_q, npc_d;

   logic               mem_req_c, accept_c, resp_c, fwd_c;

   assign tag_in_c  = '{pc: pc_q, bp_hit: iBP_HIT, bp_addr: iBP_ADDR,
                        paging: iSYSREG_PAGING_ENA, kernel: iSYSREG_KERNEL};
   assign tag_out_c = tag_mem_q[rd_ptr_q];

   // Next-state, issue and response handling
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      outst_d   = outst_q;
      drop_d    = drop_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      valid_d   = 1'b0;
      pf_d      = pf_q;
      flags_d   = flags_q;
      paging_d  = paging_q;
      kernel_d  = kernel_q;
      bp_d      = bp_q;
      bp_addr_d = bp_addr_q;
      inst_d    = inst_q;
      npc_d     = npc_q;

      mem_req_c = (state_q == ST_RUN) && !iFREE_REFRESH && !iNEXT_FETCH_STOP &&
                  !iNEXT_LOCK && (outst_q < CNT_W'(P_MAX_OUTSTANDING));
      accept_c  = mem_req_c && !iMEM_BUSY;
      resp_c    = iMEM_VALID && (outst_q != '0);
      fwd_c     = resp_c && (drop_q == '0) && !iFREE_REFRESH;

      case (state_q)
         ST_INIT: state_d = ST_RUN;
         default: state_d = ST_RUN;
      endcase

      if (accept_c) begin
         pc_d     = iBP_HIT ? (iBP_ADDR & 32'hFFFF_FFFC) : (pc_q + 32'd4);
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (iFREE_REFRESH) begin
         pc_d = iREFRESH_PC & 32'hFFFF_FFFC;
      end

      if (resp_c) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      outst_d = outst_q + CNT_W'(accept_c) - CNT_W'(resp_c);

      // Refresh reloads the stale count with whatever is still in flight
      if (iFREE_REFRESH) begin
         drop_d = outst_q - CNT_W'(resp_c);
      end else if (resp_c && (drop_q != '0)) begin
         drop_d = drop_q - CNT_W'(1);
      end

      if (fwd_c) begin
         valid_d   = 1'b1;
         pf_d      = iMEM_PAGEFAULT;
         flags_d   = iMEM_MMU_FLAGS;
         paging_d  = tag_out_c.paging;
         kernel_d  = tag_out_c.kernel;
         bp_d      = tag_out_c.bp_hit;
         bp_addr_d = tag_out_c.bp_addr;
         inst_d    = iMEM_DATA;
         npc_d     = tag_out_c.pc;
      end
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge iCLOCK) begin
      if (!inRESET) begin
         state_q   <= ST_INIT;
         pc_q      <= P_RESET_PC;
         outst_q   <= '0;
         drop_q    <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         valid_q   <= 1'b0;
         pf_q      <= 1'b0;
         flags_q   <= '0;
         paging_q  <= 1'b0;
         kernel_q  <= 1'b0;
         bp_q      <= 1'b0;
         bp_addr_q <= '0;
         inst_q    <= '0;
         npc_q     <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         outst_q   <= outst_d;
         drop_q    <= drop_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         valid_q   <= valid_d;
         pf_q      <= pf_d;
         flags_q   <= flags_d;
         paging_q  <= paging_d;
         kernel_q  <= kernel_d;
         bp_q      <= bp_d;
         bp_addr_q <= bp_addr_d;
         inst_q    <= inst_d;
         npc_q     <= npc_d;
      end
   end

   // Tag FIFO storage; emptiness is tracked by the pointers and counter
   always_ff @(posedge iCLOCK) begin
      if (accept_c) begin
         tag_mem_q[wr_ptr_q] <= tag_in_c;
      end
   end

   assign oMEM_REQ                  = mem_req_c;
   assign oMEM_ADDR                 = pc_q;
   assign oNEXT_INST_VALID          = valid_q && !iFREE_REFRESH;
   assign oNEXT_PAGEFAULT           = pf_q;
   assign oNEXT_MMU_FLAGS           = flags_q;
   assign oNEXT_PAGING_ENA          = paging_q;
   assign oNEXT_KERNEL_ACCESS       = kernel_q;
   assign oNEXT_BRANCH_PREDICT      = bp_q;
   assign oNEXT_BRANCH_PREDICT_ADDR = bp_addr_q;
   assign oNEXT_INST                = inst_q;
   assign oNEXT_PC                  = npc_q;

endmodule
